// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display arbiter: state encoding,
// display word width and the default dwell at a 50 MHz system clock.
package display_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_ARB  = 2'd2;

    localparam int DISP_W        = 32;
    localparam int DWELL_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SHOW = ST_SHOW,
        ARB  = ST_ARB
    } state_t;
endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin first-set search: scans req upward from i_ptr with
// wrap-around, skipping any bit set in i_excl, and returns a one-hot winner.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic [N-1:0]  i_excl,
    output logic          o_found,
    output logic [N-1:0]  o_winner
);
    logic [N-1:0]  w_masked;
    logic [IW-1:0] w_idx [N];

    assign w_masked = i_req & ~i_excl;

    // Search order: w_idx[k] = (ptr + k) mod N; ptr < N keeps one subtraction enough.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_idx
            logic [IW:0] w_sum;
            assign w_sum      = {1'b0, i_ptr} + (IW+1)'(gi);
            assign w_idx[gi]  = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
        end
    endgenerate

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && w_masked[w_idx[k]]) begin
                o_found            = 1'b1;
                o_winner[w_idx[k]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 8-digit display word, with a minimum dwell
// per owner and a seamless (never blanked) hand-over between owners.
module display_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int DWELL = DWELL_DEFAULT,
    parameter int CNT_W = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [DISP_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic [DISP_W-1:0]       nums,
    output logic                    en,
    output logic                    switch_pulse
);
    localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t             r_state, w_state_next;
    logic [N_REQ-1:0]   r_gnt, w_gnt_next;
    logic [DISP_W-1:0]  r_nums, w_nums_next;
    logic               r_en, w_en_next;
    logic               r_pulse, w_pulse_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [IDX_W-1:0]   r_ptr, w_ptr_next;
    logic [IDX_W-1:0]   r_owner, w_owner_next;

    logic [DISP_W-1:0]  w_words [N_REQ];
    logic [N_REQ-1:0]   w_owner_onehot;
    logic [IDX_W-1:0]   w_ptr_inc;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [N_REQ-1:0]   w_pick_excl;
    logic               w_found;
    logic [N_REQ-1:0]   w_winner;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_others;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_words[gi]        = data[DISP_W*gi +: DISP_W];
            assign w_owner_onehot[gi] = (r_owner == IDX_W'(gi));
        end
    endgenerate

    assign w_ptr_inc = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_others  = |(req & ~w_owner_onehot);

    // One search unit serves both IDLE (from the pointer) and ARB (past the owner).
    assign w_pick_ptr  = (r_state == ARB) ? w_ptr_inc : r_ptr;
    assign w_pick_excl = (r_state == ARB) ? w_owner_onehot : '0;

    rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
        .i_req    (req),
        .i_ptr    (w_pick_ptr),
        .i_excl   (w_pick_excl),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner[i]) w_win_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_nums_next  = r_nums;
        w_en_next    = r_en;
        w_pulse_next = 1'b0;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        case (r_state)
            IDLE: begin
                w_en_next = 1'b0;
                if (w_found) begin
                    w_gnt_next   = w_winner;
                    w_owner_next = w_win_idx;
                    w_nums_next  = w_words[w_win_idx];
                    w_en_next    = 1'b1;
                    w_pulse_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = SHOW;
                end
            end
            SHOW: begin
                w_nums_next = w_words[r_owner];
                if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
                // A dropped request wins over an expiring dwell; both lead to ARB.
                if (!req[r_owner]) begin
                    w_state_next = ARB;
                end else if (r_cnt == CNT_MAX && w_others) begin
                    w_state_next = ARB;
                end
            end
            ARB: begin
                w_ptr_next = w_ptr_inc;
                if (w_found) begin
                    w_gnt_next   = w_winner;
                    w_owner_next = w_win_idx;
                    w_nums_next  = w_words[w_win_idx];
                    w_pulse_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = SHOW;
                end else if (req[r_owner]) begin
                    w_cnt_next   = '0;
                    w_state_next = SHOW;
                end else begin
                    w_gnt_next   = '0;
                    w_en_next    = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_gnt_next   = '0;
                w_en_next    = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_nums  <= '0;
            r_en    <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_nums  <= w_nums_next;
            r_en    <= w_en_next;
            r_pulse <= w_pulse_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_owner <= w_owner_next;
        end
    end

    assign gnt          = r_gnt;
    assign nums         = r_nums;
    assign en           = r_en;
    assign switch_pulse = r_pulse;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (N_REQ=3, DWELL=8): expected outputs are
// queued as each step is driven and compared one cycle later.
module tb_display_arbiter;
    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] d [3];
    logic [95:0] data;
    logic [2:0]  gnt;
    logic [31:0] nums;
    logic        en;
    logic        switch_pulse;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [2:0]  gnt;
        logic        en;
        logic [31:0] nums;
        logic        pulse;
    } exp_t;

    exp_t sb_q[$];

    assign data = {d[2], d[1], d[0]};

    display_arbiter #(.N_REQ(3), .DWELL(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data         (data),
        .gnt          (gnt),
        .nums         (nums),
        .en           (en),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_total++;
        assert ($onehot0(gnt)) n_pass++;
        else $error("FAIL gnt_onehot: got gnt=%b, required one-hot or zero", gnt);
    end

    task automatic push_exp(input string tag, input logic [2:0] g, input logic e,
                            input logic [31:0] n, input logic p);
        exp_t x;
        x.tag   = tag;
        x.gnt   = g;
        x.en    = e;
        x.nums  = n;
        x.pulse = p;
        sb_q.push_back(x);
    endtask

    task automatic pop_check();
        exp_t        x;
        logic [36:0] obs;
        logic [36:0] exp_v;
        n_total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: got no queued entry, required one");
            return;
        end
        x     = sb_q.pop_front();
        obs   = {gnt, en, nums, switch_pulse};
        exp_v = {x.gnt, x.en, x.nums, x.pulse};
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got gnt=%b en=%b nums=%h pulse=%b, required gnt=%b en=%b nums=%h pulse=%b",
                    x.tag, gnt, en, nums, switch_pulse, x.gnt, x.en, x.nums, x.pulse);
    endtask

    task automatic step(input string tag, input logic [2:0] g, input logic e,
                        input logic [31:0] n, input logic p);
        push_exp(tag, g, e, n, p);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_now(input string tag, input logic [2:0] g, input logic e,
                             input logic [31:0] n, input logic p);
        push_exp(tag, g, e, n, p);
        pop_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no end of run by 20000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         o;
        logic [2:0] g;

        rst  = 1'b0;
        req  = 3'b000;
        d[0] = '0;
        d[1] = '0;
        d[2] = '0;
        #1 rst = 1'b1;
        #2 check_now("reset", 3'b000, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) step("idle_hold", 3'b000, 1'b0, 32'h0, 1'b0);

        // Single requester keeps the display indefinitely and tracks live data.
        d[0] = 32'h12345678;
        req  = 3'b001;
        step("s2_grant", 3'b001, 1'b1, 32'h12345678, 1'b1);
        d[0] = 32'h87654321;
        step("s2_follow", 3'b001, 1'b1, 32'h87654321, 1'b0);
        for (int i = 0; i < 12; i++) step("s2_keep", 3'b001, 1'b1, 32'h87654321, 1'b0);
        req = 3'b000;
        step("s2_release_arb", 3'b001, 1'b1, 32'h87654321, 1'b0);
        step("s2_idle", 3'b000, 1'b0, 32'h87654321, 1'b0);

        do_reset();
        check_now("s3_reset", 3'b000, 1'b0, 32'h0, 1'b0);
        d[0] = 32'h11111111;
        d[1] = 32'h22222222;
        d[2] = 32'h33333333;
        req  = 3'b111;
        for (int r = 0; r < 4; r++) begin
            o = r % 3;
            g = 3'b001 << o;
            step("s3_switch", g, 1'b1, d[o], 1'b1);
            if (r < 3) begin
                for (int c = 0; c < 8; c++) step("s3_hold", g, 1'b1, d[o], 1'b0);
            end
        end

        // Early release by owner 1 at count 3 while requester 2 waits.
        do_reset();
        req = 3'b010;
        step("s4_grant", 3'b010, 1'b1, 32'h22222222, 1'b1);
        req = 3'b110;
        for (int i = 0; i < 3; i++) step("s4_show", 3'b010, 1'b1, 32'h22222222, 1'b0);
        req = 3'b100;
        step("s4_drop_arb", 3'b010, 1'b1, 32'h22222222, 1'b0);
        step("s4_to_2", 3'b100, 1'b1, 32'h33333333, 1'b1);
        req = 3'b000;
        step("s4_arb_empty", 3'b100, 1'b1, 32'h33333333, 1'b0);
        step("s4_idle", 3'b000, 1'b0, 32'h33333333, 1'b0);

        // Owner 2 drops exactly as its dwell counter reaches 7; requester 0 waits.
        req = 3'b100;
        step("s5_grant", 3'b100, 1'b1, 32'h33333333, 1'b1);
        req = 3'b101;
        for (int i = 0; i < 7; i++) step("s5_show", 3'b100, 1'b1, 32'h33333333, 1'b0);
        req = 3'b001;
        step("s5_drop_arb", 3'b100, 1'b1, 32'h33333333, 1'b0);
        step("s5_to_0", 3'b001, 1'b1, 32'h11111111, 1'b1);
        step("s5_single_pulse", 3'b001, 1'b1, 32'h11111111, 1'b0);

        // Asynchronous reset in the middle of a SHOW period.
        d[0] = 32'habcdffff;
        step("s6_show", 3'b001, 1'b1, 32'habcdffff, 1'b0);
        #3 rst = 1'b1;
        #1 check_now("s6_async_clear", 3'b000, 1'b0, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        req = 3'b010;
        step("s6_regrant", 3'b010, 1'b1, 32'h22222222, 1'b1);
        step("s6_hold", 3'b010, 1'b1, 32'h22222222, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
